// File: rtl/dn_write_sequencer.sv
// rtl/dn_write_sequencer.sv - single owner of the core download write port (ioctl FIFO + hiscore)
module dn_write_sequencer #(
   parameter int unsigned ROM_INDEX  = 0,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WR_GAP     = 3,
   parameter int unsigned RESET_TAIL = 16
) (
   input  logic        i_clk_sys,
   input  logic        i_reset_n,
   input  logic        i_ioctl_download,
   input  logic        i_ioctl_wr,
   input  logic [15:0] i_ioctl_index,
   input  logic [17:0] i_ioctl_addr,
   input  logic [7:0]  i_ioctl_dout,
   input  logic        i_hs_req,
   input  logic [17:0] i_hs_addr,
   input  logic [7:0]  i_hs_data,
   output logic        o_hs_ack,
   output logic [17:0] o_dn_addr,
   output logic [7:0]  o_dn_data,
   output logic        o_dn_wr,
   output logic        o_core_reset,
   output logic        o_fifo_ovf,
   output logic        o_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(WR_GAP + 1);
   localparam int TW = $clog2(RESET_TAIL + 1);

   // GAP holds for WR_GAP-1 cycles, so the down-counter starts at WR_GAP-2
   localparam logic [GW-1:0] GAP_LOAD  = GW'((WR_GAP > 1) ? (WR_GAP - 2) : 0);
   localparam logic [TW-1:0] TAIL_LOAD = TW'(RESET_TAIL);
   localparam logic [15:0]   ROM_IDX   = 16'(ROM_INDEX);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GAP
   } state_t;

   // ioctl byte FIFO: entries are {addr, data}; pointers carry one wrap bit
   logic [25:0]   r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic          r_fifo_ovf;

   state_t        r_state;
   logic [GW-1:0] r_gap_cnt;
   logic [17:0]   r_dn_addr;
   logic [7:0]    r_dn_data;
   logic          r_dn_wr;
   logic          r_hs_ack;

   logic          r_core_reset;
   logic [TW-1:0] r_tail_cnt;

   logic          w_empty;
   logic          w_full;
   logic          w_push_req;
   logic          w_pop;
   logic          w_push;
   logic          w_busy;
   logic [25:0]   w_head;

   assign w_empty    = (r_wptr == r_rptr);
   assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push_req = i_ioctl_wr && i_ioctl_download && (i_ioctl_index == ROM_IDX);
   // FIFO wins over hiscore whenever the FSM is free to decide
   assign w_pop      = (r_state == ST_IDLE) && !w_empty;
   // a full FIFO still takes a byte when the head leaves in the same cycle
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_head     = r_mem[r_rptr[AW-1:0]];
   assign w_busy     = !w_empty || (r_state != ST_IDLE);

   // FIFO storage write; contents need no reset because the pointers define validity
   always_ff @(posedge i_clk_sys) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= {i_ioctl_addr, i_ioctl_dout};
      end
   end

   // FIFO pointers and the sticky overflow flag for bytes that found no room
   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_fifo_ovf <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + (AW+1)'(1);
         end
         if (w_push_req && w_full && !w_pop) begin
            r_fifo_ovf <= 1'b1;
         end
      end
   end

   // write FSM: pick a source in IDLE, strobe for one cycle in ISSUE, then pace through GAP
   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state   <= ST_IDLE;
         r_gap_cnt <= '0;
         r_dn_addr <= '0;
         r_dn_data <= '0;
         r_dn_wr   <= 1'b0;
         r_hs_ack  <= 1'b0;
      end else begin
         r_dn_wr  <= 1'b0;
         r_hs_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_dn_addr <= w_head[25:8];
                  r_dn_data <= w_head[7:0];
                  r_dn_wr   <= 1'b1;
                  r_state   <= ST_ISSUE;
               end else if (i_hs_req && !r_core_reset) begin
                  // hiscore is held off while the core is in reset; the requester keeps waiting
                  r_dn_addr <= i_hs_addr;
                  r_dn_data <= i_hs_data;
                  r_dn_wr   <= 1'b1;
                  r_hs_ack  <= 1'b1;
                  r_state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (WR_GAP > 1) begin
                  r_gap_cnt <= GAP_LOAD;
                  r_state   <= ST_GAP;
               end else begin
                  r_state   <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // core hold-reset: held through download and drain, then released after a settling tail
   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_core_reset <= 1'b1;
         r_tail_cnt   <= TAIL_LOAD;
      end else if (i_ioctl_download || w_busy) begin
         r_core_reset <= 1'b1;
         r_tail_cnt   <= TAIL_LOAD;
      end else if (r_tail_cnt != '0) begin
         r_tail_cnt <= r_tail_cnt - TW'(1);
         if (r_tail_cnt == TW'(1)) begin
            r_core_reset <= 1'b0;
         end
      end
   end

   assign o_hs_ack     = r_hs_ack;
   assign o_dn_addr    = r_dn_addr;
   assign o_dn_data    = r_dn_data;
   assign o_dn_wr      = r_dn_wr;
   assign o_core_reset = r_core_reset;
   assign o_fifo_ovf   = r_fifo_ovf;
   assign o_busy       = w_busy;

endmodule

// File: tb/tb_dn_write_sequencer.sv
// tb/tb_dn_write_sequencer.sv - scoreboard bench for dn_write_sequencer
module tb_dn_write_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [15:0] ioctl_index = '0;
   logic [17:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        hs_req = 1'b0;
   logic [17:0] hs_addr = '0;
   logic [7:0]  hs_data = '0;
   logic        hs_ack;
   logic [17:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;
   logic        core_reset;
   logic        fifo_ovf;
   logic        busy;

   typedef struct {
      logic [17:0] addr;
      logic [7:0]  data;
      logic        hs;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic prev_wr = 1'b0;

   dn_write_sequencer #(
      .ROM_INDEX(0), .FIFO_DEPTH(4), .WR_GAP(3), .RESET_TAIL(16)
   ) dut (
      .i_clk_sys(clk), .i_reset_n(rst_n),
      .i_ioctl_download(ioctl_download), .i_ioctl_wr(ioctl_wr),
      .i_ioctl_index(ioctl_index), .i_ioctl_addr(ioctl_addr), .i_ioctl_dout(ioctl_dout),
      .i_hs_req(hs_req), .i_hs_addr(hs_addr), .i_hs_data(hs_data), .o_hs_ack(hs_ack),
      .o_dn_addr(dn_addr), .o_dn_data(dn_data), .o_dn_wr(dn_wr),
      .o_core_reset(core_reset), .o_fifo_ovf(fifo_ovf), .o_busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_byte(input logic [17:0] a, input logic [7:0] d, input logic [15:0] idx);
      ioctl_wr    = 1'b1;
      ioctl_addr  = a;
      ioctl_dout  = d;
      ioctl_index = idx;
   endtask

   task automatic wait_drain(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         if (sb.size() == 0 && !busy) break;
         step(1);
      end
      chk(tag, {30'd0, sb.size() == 0, !busy}, 32'd3);
   endtask

   task automatic wait_ack(input string tag, input int n);
      logic got;
      got = 1'b0;
      for (int k = 0; k < n; k++) begin
         step(1);
         if (hs_ack) begin
            got = 1'b1;
            break;
         end
      end
      chk(tag, {31'd0, got}, 32'd1);
   endtask

   // output monitor: every write must match the scoreboard head in content and cycle
   always @(negedge clk) begin
      if (dn_wr) begin
         chk("wr_spacing", {31'd0, prev_wr}, 32'd0);
         chk("wr_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("wr_addr", {14'd0, dn_addr}, {14'd0, e.addr});
            chk("wr_data", {24'd0, dn_data}, {24'd0, e.data});
            chk("wr_ack", {31'd0, hs_ack}, {31'd0, e.hs});
            chk("wr_cycle", cyc, e.cyc);
         end
      end else if (hs_ack) begin
         chk("ack_without_wr", {31'd0, hs_ack}, 32'd0);
      end
      prev_wr = dn_wr;
   end

   initial begin
      int hi;
      int c0;

      // reset state
      step(3);
      chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
      chk("rst_outputs", {dn_wr, hs_ack, busy, fifo_ovf, |dn_addr, |dn_data}, 32'd0);

      // release: core_reset for exactly 16 cycles, nothing else moves
      rst_n = 1'b1;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (core_reset) hi++;
         chk("quiet_outputs", {dn_wr, hs_ack, busy, fifo_ovf, |dn_addr, |dn_data}, 32'd0);
         step(1);
      end
      chk("reset_tail_len", hi, 16);
      chk("reset_tail_done", {31'd0, core_reset}, 32'd0);

      // single download byte, N+2 latency; wrong-index byte ignored
      ioctl_download = 1'b1;
      step(2);
      drive_byte(18'h00123, 8'hA5, 16'd0);
      sb.push_back('{18'h00123, 8'hA5, 1'b0, cyc + 2});
      step(1);
      drive_byte(18'h00200, 8'h77, 16'd1);
      step(1);
      ioctl_wr = 1'b0;
      step(10);
      chk("single_drained", sb.size(), 0);
      chk("hold_addr", {14'd0, dn_addr}, 32'h00123);
      chk("hold_data", {24'd0, dn_data}, 32'hA5);
      chk("no_ovf_wrong_idx", {31'd0, fifo_ovf}, 32'd0);

      // burst of 8 back-to-back bytes into a 4-deep FIFO
      wait_drain("pre_burst_idle", 20);
      c0 = cyc;
      for (int i = 0; i < 8; i++) begin
         drive_byte(18'h00100 + 18'(i), 8'h10 + 8'(i), 16'd0);
         if (i < 6) sb.push_back('{18'h00100 + 18'(i), 8'h10 + 8'(i), 1'b0, c0 + 2 + 4 * i});
         step(1);
      end
      ioctl_wr = 1'b0;
      wait_drain("burst_drain", 60);
      chk("burst_ovf", {31'd0, fifo_ovf}, 32'd1);

      // tail restart: drop, re-raise 5 cycles later, drop again
      ioctl_download = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("tail_gap_hold", {31'd0, core_reset}, 32'd1);
         step(1);
      end
      ioctl_download = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("tail_dl_hold", {31'd0, core_reset}, 32'd1);
         step(1);
      end
      ioctl_download = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("tail_restart_hold", {31'd0, core_reset}, 32'd1);
         step(1);
      end
      chk("tail_restart_fall", {31'd0, core_reset}, 32'd0);

      // hiscore with core running: ack one cycle later
      hs_req  = 1'b1;
      hs_addr = 18'h3F000;
      hs_data = 8'h5A;
      sb.push_back('{18'h3F000, 8'h5A, 1'b1, cyc + 1});
      wait_ack("hs_ack_seen", 10);
      hs_req = 1'b0;
      step(3);
      chk("hs_drained", sb.size(), 0);
      chk("ovf_sticky", {31'd0, fifo_ovf}, 32'd1);

      // hiscore during download: held off until the download ends and the tail expires
      ioctl_download = 1'b1;
      step(2);
      hs_req  = 1'b1;
      hs_addr = 18'h3F001;
      hs_data = 8'hC3;
      step(6);
      ioctl_download = 1'b0;
      sb.push_back('{18'h3F001, 8'hC3, 1'b1, cyc + 17});
      wait_ack("hs_gated_ack_seen", 40);
      hs_req = 1'b0;
      step(2);
      chk("hs_gated_drained", sb.size(), 0);

      // async reset with three bytes still queued
      ioctl_download = 1'b1;
      step(2);
      c0 = cyc;
      for (int i = 0; i < 4; i++) begin
         drive_byte(18'h00200 + 18'(i), 8'h80 + 8'(i), 16'd0);
         if (i == 0) sb.push_back('{18'h00200, 8'h80, 1'b0, c0 + 2});
         step(1);
      end
      ioctl_wr = 1'b0;
      chk("queued_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_core_reset", {31'd0, core_reset}, 32'd1);
      chk("async_outputs", {dn_wr, hs_ack, busy, fifo_ovf, |dn_addr, |dn_data}, 32'd0);
      chk("async_sb", sb.size(), 0);
      step(2);
      ioctl_download = 1'b0;
      rst_n = 1'b1;
      step(30);
      chk("post_rst_ovf", {31'd0, fifo_ovf}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_sb", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
